uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Consumes the received-byte stream from the UART receiver (8-bit data plus a one-cycle valid pulse) and decodes a small binary command protocol.
- Issues single-word SDRAM write/read requests to the memory controller front end.
- Returns an ack byte or the read data to the UART transmitter.
- Sits between the UART RX/TX pair and the SDRAM controller on the DE1-SoC.

Parameters:
- ADDR_W, 24, memory word-address width (1..24); upper address bits beyond ADDR_W are discarded.
- TIMEOUT_CYCLES, 20000, inter-byte timeout in clk cycles; used only with CMD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_addr  out  ADDR_W  word address; stable while mem_req=1
- mem_wdata  out  16  write data; stable while mem_req=1
- mem_ready  in  1  request accepted in any cycle where mem_req & mem_ready
- mem_rdata  in  16  read data
- mem_rvalid  in  1  one-cycle pulse, read data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse launching transmission of tx_data
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start
- err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_data=0, tx_start=0, err=0; byte counter=0.
- Protocol: opcode byte, then 3 address bytes MSB first; write adds 2 data bytes MSB first.
  - Opcode 'W' = 0x57 for write, 'R' = 0x52 for read.
  - Address = {a2,a1,a0}[ADDR_W-1:0].
- States: IDLE, ADDR, DATA, ISSUE, WAIT_RD, TX, TX_WAIT.
- IDLE:
  - rx_valid with 0x57 or 0x52 -> latch opcode, go to ADDR with count=0.
  - Any other byte -> err pulse next cycle, stay IDLE.
- ADDR: each rx_valid shifts the byte into the address register. After the 3rd byte, go to DATA for a write or ISSUE for a read.
- DATA: each rx_valid shifts into wdata. After the 2nd byte, go to ISSUE.
- Request timing: last command byte's rx_valid at cycle N -> mem_req=1 at N+1.
- ISSUE:
  - Hold mem_req/we/addr/wdata until the cycle with mem_ready=1; mem_req drops the following cycle.
  - Write accepted -> tx_data=0x4B ('K'), go to TX.
  - Read accepted -> go to WAIT_RD.
  - mem_ready may already be high at N+1, giving single-cycle acceptance.
- WAIT_RD: on mem_rvalid, capture mem_rdata and go to TX with tx_data = rdata[15:8]. mem_rvalid outside WAIT_RD is ignored.
- TX:
  - When tx_busy=0, pulse tx_start for one cycle and go to TX_WAIT.
  - mem_rvalid at cycle M with tx idle -> tx_start at M+1.
- TX_WAIT:
  - Skip the cycle right after tx_start, then wait for tx_busy=0.
  - If a read low byte is pending, load tx_data=rdata[7:0] and go to TX; otherwise go to IDLE.
- Bytes arriving in ISSUE/WAIT_RD/TX/TX_WAIT are dropped with an err pulse; state is unaffected.
- err: one cycle wide; overlapping causes produce a single pulse.
- Reset mid-operation aborts everything, including a held mem_req and a pending transmit.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/DATA and clears on every accepted rx_valid.
  - Reaching TIMEOUT_CYCLES-1 without a byte returns the FSM to IDLE with an err pulse; the partial command is discarded.
  - If rx_valid arrives in the expiry cycle, the byte wins: it is accepted and the counter clears.
  - The counter is inactive in other states.
- Not defined: no counter logic; a partial command waits indefinitely.

Test Plan:
- Write path: bytes 57 00 12 34 AB CD with mem_ready=1 -> one mem_req cycle with we=1, addr=0x001234, wdata=0xABCD; then tx_start with tx_data=0x4B.
- Read path: bytes 52 00 00 10, mem_ready delayed 5 cycles, mem_rvalid with rdata=0xBEEF 3 cycles later:
  - mem_req held 6 cycles with addr=0x000010, we=0.
  - tx_start with 0xBE, then 0xEF only after tx_busy falls.
- Bad opcode 0x41 -> err pulse, no mem_req; a following 52 00 00 01 executes normally.
- Byte 0x57 sent during WAIT_RD -> err pulse; the read completes with correct data; the FSM is back in IDLE afterwards.
- With CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100:
  - Send 57 00 then idle 100 cycles -> err pulse, IDLE.
  - Then 52 00 00 02 issues a read of 0x000002.
  - Without the macro, the same stimulus gives no err.
- Assert rst_n low while mem_req is held -> all outputs zero immediately; after release, a new write command executes correctly.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Bus bundle between the UART command parser and its neighbours:
// the UART RX byte stream, the SDRAM front-end request/response, the UART TX
// launch/busy pair, and the protocol error pulse.
//   master : the parser's view (drives mem_*, tx_data/tx_start, err).
//   slave  : the environment's view (drives rx_*, mem_ready/rdata/rvalid, tx_busy).
interface uart_cmd_parser_if #(
  parameter int ADDR_W = 24
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ready;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              err;

  modport master (
    input  rx_data, rx_valid, mem_ready, mem_rdata, mem_rvalid, tx_busy,
    output mem_req, mem_we, mem_addr, mem_wdata, tx_data, tx_start, err
  );

  modport slave (
    output rx_data, rx_valid, mem_ready, mem_rdata, mem_rvalid, tx_busy,
    input  mem_req, mem_we, mem_addr, mem_wdata, tx_data, tx_start, err
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART binary command parser.
// Decodes 'W' a2 a1 a0 d1 d0 (write) and 'R' a2 a1 a0 (read) from the RX
// byte stream, issues one SDRAM word request, then answers over TX with
// 'K' for a write or the two read-data bytes (MSB first) for a read.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : uart_cmd_parser_if.master (rx_*, mem_*, tx_*, err)
// Optional build macro CMD_TIMEOUT_EN: abandons a partial command after
// TIMEOUT_CYCLES idle clocks in ADDR/DATA with an err pulse.
module uart_cmd_parser #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_parser_if.master  bus
);
  if (ADDR_W < 1 || ADDR_W > 24 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_cmd_parser: unsupported parameter values");
  end

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT_RD, TX, TX_WAIT} state_e;

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h4B;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        rlo_q, rlo_d;
  logic              lo_pend_q, lo_pend_d;
  logic              req_q, req_d;
  logic              mwe_q, mwe_d;
  logic [7:0]        txd_q, txd_d;
  logic              txs_q, txs_d;
  logic              err_q, err_d;
  logic              tmo_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_cmd;

  assign in_cmd  = (state_q == ADDR) || (state_q == DATA);
  // A byte in the expiry cycle wins over the timeout.
  assign tmo_hit = in_cmd && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (in_cmd && !bus.rx_valid && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_we_d   = op_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rlo_d     = rlo_q;
    lo_pend_d = lo_pend_q;
    req_d     = req_q;
    mwe_d     = mwe_q;
    txd_d     = txd_q;
    txs_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: if (bus.rx_valid) begin
        if (bus.rx_data == OP_W || bus.rx_data == OP_R) begin
          op_we_d = (bus.rx_data == OP_W);
          cnt_d   = '0;
          state_d = ADDR;
        end else begin
          err_d = 1'b1;
        end
      end
      ADDR: if (bus.rx_valid) begin
        // Shifting through an ADDR_W-wide register drops the excess high bits.
        addr_d = ADDR_W'({addr_q, bus.rx_data});
        if (cnt_q == 2'd2) begin
          cnt_d = '0;
          if (op_we_q) state_d = DATA;
          else begin
            state_d = ISSUE;
            req_d   = 1'b1;
            mwe_d   = 1'b0;
          end
        end else cnt_d = cnt_q + 2'd1;
      end else if (tmo_hit) begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end
      DATA: if (bus.rx_valid) begin
        wdata_d = {wdata_q[7:0], bus.rx_data};
        if (cnt_q == 2'd1) begin
          cnt_d   = '0;
          state_d = ISSUE;
          req_d   = 1'b1;
          mwe_d   = 1'b1;
        end else cnt_d = cnt_q + 2'd1;
      end else if (tmo_hit) begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end
      ISSUE: if (bus.mem_ready) begin
        req_d = 1'b0;
        mwe_d = 1'b0;
        if (op_we_q) begin
          // Launch straight away when the transmitter is idle.
          txd_d   = ACK;
          txs_d   = !bus.tx_busy;
          state_d = bus.tx_busy ? TX : TX_WAIT;
        end else state_d = WAIT_RD;
      end
      WAIT_RD: if (bus.mem_rvalid) begin
        txd_d     = bus.mem_rdata[15:8];
        rlo_d     = bus.mem_rdata[7:0];
        lo_pend_d = 1'b1;
        txs_d     = !bus.tx_busy;
        state_d   = bus.tx_busy ? TX : TX_WAIT;
      end
      TX: if (!bus.tx_busy) begin
        txs_d   = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        // tx_busy only rises the cycle after tx_start, so ignore that cycle.
        if (!txs_q && !bus.tx_busy) begin
          if (lo_pend_q) begin
            txd_d     = rlo_q;
            lo_pend_d = 1'b0;
            state_d   = TX;
          end else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.rx_valid && (state_q inside {ISSUE, WAIT_RD, TX, TX_WAIT})) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_we_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rlo_q     <= '0;
      lo_pend_q <= 1'b0;
      req_q     <= 1'b0;
      mwe_q     <= 1'b0;
      txd_q     <= '0;
      txs_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_we_q   <= op_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rlo_q     <= rlo_d;
      lo_pend_q <= lo_pend_d;
      req_q     <= req_d;
      mwe_q     <= mwe_d;
      txd_q     <= txd_d;
      txs_q     <= txs_d;
      err_q     <= err_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.tx_data   = txd_q;
  assign bus.tx_start  = txs_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: write, delayed read, bad opcode,
// byte during WAIT_RD, partial-command timeout (both builds), reset abort.
module tb_uart_cmd_parser;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_W(AW)) bus ();
  uart_cmd_parser #(.ADDR_W(AW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  int req_cnt, req_len, req_first, err_cnt, tx_viol, tx_first, rv_set, last_rx;
  bit req_prev, req_unstable;
  logic [AW-1:0] req_addr;
  logic req_we;
  logic [15:0] req_wd;
  byte unsigned tx_log[$];

  // model knobs/state
  int rdly, rv_dly, rq_k, rv_k, txb_k;
  bit rv_arm, start_pend;
  logic [15:0] rd_val;

  // Monitor first, then TX and memory models, all in one process so the
  // monitor sees this negedge's values before the models change them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req) begin
        if (!req_prev) begin
          req_cnt++; req_len = 0; req_first = cyc;
          req_addr = bus.mem_addr; req_we = bus.mem_we; req_wd = bus.mem_wdata;
        end else if (bus.mem_addr !== req_addr || bus.mem_we !== req_we || bus.mem_wdata !== req_wd)
          req_unstable = 1;
        req_len++;
      end
      if (bus.err) err_cnt++;
      if (bus.tx_start) begin
        if (tx_log.size() == 0) tx_first = cyc;
        tx_log.push_back(bus.tx_data);
        if (bus.tx_busy) tx_viol++;
      end
    end
    req_prev = bus.mem_req;

    if (!rst_n) begin
      txb_k = 0; start_pend = 0;
    end else begin
      if (txb_k > 0) txb_k--;
      if (start_pend) begin txb_k = 6; start_pend = 0; end
      if (bus.tx_start) start_pend = 1;
    end
    bus.tx_busy = (txb_k > 0);

    bus.mem_rvalid = 1'b0;
    if (!rst_n) begin
      rq_k = 0; rv_arm = 0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    end else begin
      if (rv_arm) begin
        rv_k++;
        if (rv_k >= rv_dly) begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = rd_val; rv_arm = 0; rv_set = cyc;
        end
      end
      if (bus.mem_req) begin
        rq_k++;
        bus.mem_ready = (rq_k > rdly);
        if (bus.mem_ready && !bus.mem_we) begin rv_arm = 1; rv_k = 0; end
      end else begin
        rq_k = 0; bus.mem_ready = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] txb(input int i);
    return (tx_log.size() > i) ? 32'(tx_log[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    tx_log.delete(); req_cnt = 0; err_cnt = 0; tx_viol = 0; req_unstable = 0;
  endtask

  task automatic send(input byte unsigned b);
    @(negedge clk); bus.rx_data = b; bus.rx_valid = 1'b1; last_rx = cyc;
    @(negedge clk); bus.rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
    rdly = 0; rv_dly = 3; rd_val = '0;
    rst_n = 1'b0;
    settle(3);
    chk("rst_req",   bus.mem_req, 0);
    chk("rst_we",    bus.mem_we, 0);
    chk("rst_addr",  bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_txd",   bus.tx_data, 0);
    chk("rst_txs",   bus.tx_start, 0);
    chk("rst_err",   bus.err, 0);
    @(negedge clk) rst_n = 1'b1;
    settle(2);

    // write with immediate ready
    clr(); rdly = 0;
    send(8'h57); send(8'h00); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    settle(30);
    chk("wr_req_n",  req_cnt, 1);
    chk("wr_len",    req_len, 1);
    chk("wr_lat",    req_first - last_rx, 1);
    chk("wr_we",     req_we, 1);
    chk("wr_addr",   req_addr, 24'h001234);
    chk("wr_wdata",  req_wd, 16'hABCD);
    chk("wr_tx_n",   tx_log.size(), 1);
    chk("wr_tx0",    txb(0), 8'h4B);
    chk("wr_err",    err_cnt, 0);

    // read with ready delayed 5 cycles, rvalid 3 cycles later
    clr(); rdly = 5; rv_dly = 3; rd_val = 16'hBEEF;
    send(8'h52); send(8'h00); send(8'h00); send(8'h10);
    settle(60);
    chk("rd_req_n",  req_cnt, 1);
    chk("rd_len",    req_len, 6);
    chk("rd_we",     req_we, 0);
    chk("rd_addr",   req_addr, 24'h000010);
    chk("rd_stable", req_unstable, 0);
    chk("rd_tx_n",   tx_log.size(), 2);
    chk("rd_tx0",    txb(0), 8'hBE);
    chk("rd_tx1",    txb(1), 8'hEF);
    chk("rd_tx_lat", tx_first - rv_set, 1);
    chk("rd_tx_busy", tx_viol, 0);

    // bad opcode, then a normal read
    clr(); rdly = 0; rd_val = 16'h1234;
    send(8'h41);
    settle(5);
    chk("bad_err",   err_cnt, 1);
    chk("bad_noreq", req_cnt, 0);
    send(8'h52); send(8'h00); send(8'h00); send(8'h01);
    settle(40);
    chk("bad_rd_n",  req_cnt, 1);
    chk("bad_rd_addr", req_addr, 24'h000001);
    chk("bad_rd_tx0", txb(0), 8'h12);
    chk("bad_rd_tx1", txb(1), 8'h34);
    chk("bad_err_tot", err_cnt, 1);

    // stray byte while waiting for read data
    clr(); rdly = 0; rv_dly = 10; rd_val = 16'hCAFE;
    send(8'h52); send(8'h00); send(8'h00); send(8'h20);
    settle(3);
    send(8'h57);
    settle(50);
    chk("wrd_err",   err_cnt, 1);
    chk("wrd_req_n", req_cnt, 1);
    chk("wrd_tx_n",  tx_log.size(), 2);
    chk("wrd_tx0",   txb(0), 8'hCA);
    chk("wrd_tx1",   txb(1), 8'hFE);
    clr();
    send(8'h57); send(8'h00); send(8'h00); send(8'h30); send(8'h00); send(8'h01);
    settle(30);
    chk("post_req_n", req_cnt, 1);
    chk("post_addr", req_addr, 24'h000030);
    chk("post_wdata", req_wd, 16'h0001);
    chk("post_tx0",  txb(0), 8'h4B);
    chk("post_err",  err_cnt, 0);

    // partial command then idle
    clr(); rv_dly = 3; rd_val = 16'h5A5A;
    send(8'h57); send(8'h00);
    settle(110);
`ifdef CMD_TIMEOUT_EN
    chk("tmo_err",   err_cnt, 1);
    chk("tmo_noreq", req_cnt, 0);
    send(8'h52); send(8'h00); send(8'h00); send(8'h02);
    settle(40);
    chk("tmo_rd_n",  req_cnt, 1);
    chk("tmo_addr",  req_addr, 24'h000002);
    chk("tmo_we",    req_we, 0);
`else
    chk("notmo_err", err_cnt, 0);
    chk("notmo_noreq", req_cnt, 0);
    send(8'h00); send(8'h02); send(8'h11); send(8'h22);
    settle(30);
    chk("notmo_req_n", req_cnt, 1);
    chk("notmo_addr", req_addr, 24'h000002);
    chk("notmo_we",  req_we, 1);
    chk("notmo_wdata", req_wd, 16'h1122);
`endif

    // reset while mem_req is held
    clr(); rdly = 1000;
    send(8'h57); send(8'h00); send(8'h00); send(8'h05); send(8'h00); send(8'h09);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    chk("rst_req_held", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   bus.mem_req, 0);
    chk("arst_we",    bus.mem_we, 0);
    chk("arst_addr",  bus.mem_addr, 0);
    chk("arst_wdata", bus.mem_wdata, 0);
    chk("arst_txd",   bus.tx_data, 0);
    chk("arst_txs",   bus.tx_start, 0);
    chk("arst_err",   bus.err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rdly = 0;
    settle(2);
    clr();
    send(8'h57); send(8'h00); send(8'h00); send(8'h07); send(8'h12); send(8'h34);
    settle(30);
    chk("ar_req_n",  req_cnt, 1);
    chk("ar_len",    req_len, 1);
    chk("ar_addr",   req_addr, 24'h000007);
    chk("ar_wdata",  req_wd, 16'h1234);
    chk("ar_we",     req_we, 1);
    chk("ar_tx0",    txb(0), 8'h4B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
